// File: rtl/jk_drive_seq.sv
// Serial (j,k) pattern driver for a JK flop: plays a word out MSB first and checks the flop's q.
// Build option JK_TOGGLE_EN: encode every q change as toggle (11) instead of set/reset.
module jk_drive_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             trk, trk_nxt;
  logic             j_nxt, k_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic             ready_nxt;
  logic             v0, e0, v1, e1;
  logic             issue_c, bit_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      trk      <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      in_ready <= 1'b1;
      v0       <= 1'b0;
      e0       <= 1'b0;
      v1       <= 1'b0;
      e1       <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      cnt      <= cnt_nxt;
      trk      <= trk_nxt;
      j        <= j_nxt;
      k        <= k_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      in_ready <= ready_nxt;
      v0       <= issue_c;
      e0       <= bit_c;
      v1       <= v0;
      e1       <= e0;
    end
  end

  // Next-state, bit issue and excitation encoding
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    ready_nxt = in_ready;
    issue_c   = 1'b0;
    bit_c     = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          issue_c   = 1'b1;
          bit_c     = in_data[WIDTH-1];
          sreg_nxt  = {in_data[WIDTH-2:0], 1'b0};
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          issue_c  = 1'b1;
          bit_c    = sreg[WIDTH-1];
          sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
          cnt_nxt  = cnt - CW'(1);
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase

    trk_nxt = issue_c ? bit_c : trk;
    j_nxt   = 1'b0;
    k_nxt   = 1'b0;
    if (issue_c && (bit_c != trk)) begin
`ifdef JK_TOGGLE_EN
      j_nxt = 1'b1;
      k_nxt = 1'b1;
`else
      j_nxt = bit_c;
      k_nxt = ~bit_c;
`endif
    end

    // Expected q is checked two edges after its command was issued
    err_nxt = err | (v1 & (q_fb != e1));
  end

endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed bench for jk_drive_seq with a behavioural JK flop closing the q_fb loop.
module tb_jk_drive_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, j, k, q_fb, busy, done, err;
  logic       q;
  logic       flip = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  jk_drive_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .j        (j),
    .k        (k),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference JK flop sharing clock and reset
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else if (j && k) q <= ~q;
    else if (j) q <= 1'b1;
    else if (k) q <= 1'b0;
  end

  assign q_fb = q ^ flip;

`ifdef JK_TOGGLE_EN
  localparam logic [15:0] JK_A5 = 16'b11_11_11_11_00_11_11_11;
  localparam logic [15:0] JK_01 = 16'b00_00_00_00_00_00_00_11;
`else
  localparam logic [15:0] JK_A5 = 16'b10_01_10_01_00_10_01_10;
  localparam logic [15:0] JK_01 = 16'b00_00_00_00_00_00_00_10;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flip  = 1'b0;
    in_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Plays one word; checks j,k per edge, handshake flags, flop q and err.
  task automatic run_word(input logic [7:0] data, input logic [15:0] exp_jk,
                          input int glitch_at, input int flip_at, input int err_from);
    logic [15:0] ejk;
    logic [7:0]  d;
    ejk = exp_jk;
    d   = data;
    in_data  = data;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("jk_E%0d", i), {30'd0, j, k}, {30'd0, ejk[15-2*i -: 2]});
      check($sformatf("flags_E%0d", i), {29'd0, busy, in_ready, done}, 32'b100);
      check($sformatf("err_E%0d", i), {31'd0, err}, {31'd0, (i >= err_from)});
      if (i >= 1) check($sformatf("q_E%0d", i), {31'd0, q}, {31'd0, d[8-i]});
      flip = (i == flip_at);
      if (i == glitch_at) begin
        in_valid = 1'b1;
        in_data  = 8'h3C;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    flip = 1'b0;
    check("jk_E8", {30'd0, j, k}, 32'd0);
    check("flags_E8", {29'd0, busy, in_ready, done}, 32'b011);
    check("q_E8", {31'd0, q}, {31'd0, d[0]});
    step();
    check("flags_E9", {29'd0, busy, in_ready, done}, 32'b010);
    check("err_E9", {31'd0, err}, {31'd0, (9 >= err_from)});
  endtask

  initial begin
    do_reset();
    check("rst_flags", {26'd0, in_ready, j, k, busy, done, err}, 32'b100000);

    // Single word 0xA5 from reset
    run_word(8'hA5, JK_A5, -1, -1, 99);

    // Busy-time in_valid pulse is ignored
    do_reset();
    run_word(8'hA5, JK_A5, 2, -1, 99);
    step();
    check("glitch_idle", {29'd0, busy, in_ready, done}, 32'b010);

    // Back-to-back 0xA5 then 0xFF with in_valid held
    do_reset();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    in_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_jk_E%0d", i), {30'd0, j, k}, {30'd0, JK_A5[15-2*i -: 2]});
      check($sformatf("b2b_rdy_E%0d", i), {31'd0, in_ready}, 32'd0);
      step();
    end
    check("b2b_E8", {27'd0, j, k, busy, in_ready, done}, 32'b00011);
    step();
    in_valid = 1'b0;
    for (int i = 9; i < 17; i++) begin
      check($sformatf("b2b_ff_E%0d", i), {28'd0, j, k, busy, in_ready}, 32'b0010);
      step();
    end
    check("b2b_E17", {27'd0, j, k, busy, in_ready, done}, 32'b00011);
    step();
    check("b2b_q", {30'd0, q, err}, 32'b10);

    // Inverted feedback on the first bit: err sets at E2 and sticks
    do_reset();
    run_word(8'hA5, JK_A5, -1, 1, 2);
    run_word(8'hFF, 16'h0000, -1, -1, 0);
    do_reset();
    check("err_cleared", {31'd0, err}, 32'd0);

    // Reset mid-word at E3, then 0x01
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst", {26'd0, in_ready, j, k, busy, done, err}, 32'b100000);
    run_word(8'h01, JK_01, -1, -1, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
